// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 decode/writeback stage.
// Holds the 15-entry register file (two write ports: valE and valM),
// decodes srcA/srcB/dstE/dstM from the fetched icode, and registers one
// packet per cycle toward execute. Tracks the run state RUN/HALT/ERR.
// Optional macro WB_BYPASS_EN: same-cycle writeback data is forwarded to
// the read ports (valM over valE). Without it, reads see the pre-write value.
// Handshake: a packet is accepted at a rising edge when in_valid=1, stall=0,
// bubble=0 and the state is RUN; out_valid marks a packet execute must run.
module decode_writeback #(
   parameter int WIDTH   = 64,
   parameter int RSP_ID  = 4,
   parameter int NONE_ID = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             bubble,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [WIDTH-1:0] valC,
   input  logic [WIDTH-1:0] valP,
   input  logic [3:0]       wb_dstE,
   input  logic [WIDTH-1:0] wb_valE,
   input  logic [3:0]       wb_dstM,
   input  logic [WIDTH-1:0] wb_valM,
   output logic             out_valid,
   output logic [3:0]       e_icode,
   output logic [3:0]       e_ifun,
   output logic [WIDTH-1:0] e_valC,
   output logic [WIDTH-1:0] e_valA,
   output logic [WIDTH-1:0] e_valB,
   output logic [3:0]       e_dstE,
   output logic [3:0]       e_dstM,
   output logic [1:0]       stat
);

   localparam logic [3:0] L_RSP  = 4'(RSP_ID);
   localparam logic [3:0] L_NONE = 4'(NONE_ID);

   localparam logic [3:0] IC_HALT   = 4'h0;
   localparam logic [3:0] IC_NOP    = 4'h1;
   localparam logic [3:0] IC_RRMOVQ = 4'h2;
   localparam logic [3:0] IC_IRMOVQ = 4'h3;
   localparam logic [3:0] IC_RMMOVQ = 4'h4;
   localparam logic [3:0] IC_MRMOVQ = 4'h5;
   localparam logic [3:0] IC_OPQ    = 4'h6;
   localparam logic [3:0] IC_JXX    = 4'h7;
   localparam logic [3:0] IC_CALL   = 4'h8;
   localparam logic [3:0] IC_RET    = 4'h9;
   localparam logic [3:0] IC_PUSHQ  = 4'hA;
   localparam logic [3:0] IC_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_regs [0:14];

   logic [3:0]       w_srcA;
   logic [3:0]       w_srcB;
   logic [3:0]       w_dstE;
   logic [3:0]       w_dstM;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;
   logic [WIDTH-1:0] w_valA;

   assign stat = r_state;

   // Register-file read; "none" reads as zero, optional same-cycle forwarding.
   function automatic logic [WIDTH-1:0] f_read(input logic [3:0] idx);
      logic [WIDTH-1:0] v;
      v = '0;
      if (idx != L_NONE && idx != 4'hF) begin
`ifdef WB_BYPASS_EN
         if (idx == wb_dstM)
            v = wb_valM;
         else if (idx == wb_dstE)
            v = wb_valE;
         else
            v = r_regs[idx];
`else
         v = r_regs[idx];
`endif
      end
      return v;
   endfunction

   // Decode source and destination register indices from icode.
   always_comb begin
      w_srcA = L_NONE;
      w_srcB = L_NONE;
      w_dstE = L_NONE;
      w_dstM = L_NONE;
      case (icode)
         IC_RRMOVQ, IC_RMMOVQ, IC_OPQ, IC_PUSHQ: w_srcA = rA;
         IC_RET, IC_POPQ:                        w_srcA = L_RSP;
         default:                                w_srcA = L_NONE;
      endcase
      case (icode)
         IC_RMMOVQ, IC_MRMOVQ, IC_OPQ:           w_srcB = rB;
         IC_CALL, IC_RET, IC_PUSHQ, IC_POPQ:     w_srcB = L_RSP;
         default:                                w_srcB = L_NONE;
      endcase
      case (icode)
         IC_RRMOVQ, IC_IRMOVQ, IC_OPQ:           w_dstE = rB;
         IC_CALL, IC_RET, IC_PUSHQ, IC_POPQ:     w_dstE = L_RSP;
         default:                                w_dstE = L_NONE;
      endcase
      case (icode)
         IC_MRMOVQ, IC_POPQ:                     w_dstM = rA;
         default:                                w_dstM = L_NONE;
      endcase
   end

   // Read ports and valA selection (jXX and call carry valP in valA).
   always_comb begin
      w_rd_a = f_read(w_srcA);
      w_rd_b = f_read(w_srcB);
      if (icode == IC_JXX || icode == IC_CALL)
         w_valA = valP;
      else
         w_valA = w_rd_a;
   end

   // Writeback into the register file; valM wins on a shared destination.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++)
            r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < 15; i++) begin
            if (wb_dstM == 4'(i) && wb_dstM != L_NONE)
               r_regs[i] <= wb_valM;
            else if (wb_dstE == 4'(i) && wb_dstE != L_NONE)
               r_regs[i] <= wb_valE;
         end
      end
   end

   // Run-state FSM and execute pipeline register (stall > bubble > capture).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         out_valid <= 1'b0;
         e_icode   <= IC_NOP;
         e_ifun    <= '0;
         e_valC    <= '0;
         e_valA    <= '0;
         e_valB    <= '0;
         e_dstE    <= L_NONE;
         e_dstM    <= L_NONE;
      end else if (stall) begin
         // Everything holds.
      end else if (bubble) begin
         out_valid <= 1'b0;
         e_icode   <= IC_NOP;
         e_ifun    <= '0;
         e_valC    <= '0;
         e_valA    <= '0;
         e_valB    <= '0;
         e_dstE    <= L_NONE;
         e_dstM    <= L_NONE;
      end else if (in_valid && r_state == ST_RUN) begin
         e_icode   <= icode;
         e_ifun    <= ifun;
         e_valC    <= valC;
         e_valA    <= w_valA;
         e_valB    <= w_rd_b;
         e_dstE    <= w_dstE;
         e_dstM    <= w_dstM;
         // An invalid instruction is never handed to execute.
         out_valid <= (icode <= IC_POPQ);
         if (icode == IC_HALT)
            r_state <= ST_HALT;
         else if (icode > IC_POPQ)
            r_state <= ST_ERR;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
Y86-64 decode/writeback stage: a 15-entry register file with two write ports (valE, valM) and two read ports selected per Y86 srcA/srcB rules.
Captures fetched fields into a single output pipeline register that drives the execute stage (icode, ifun, valC, valA, valB, plus a valid flag).
Tracks the processor run state (RUN/HALT/ERR) so the execute side stops receiving work after halt or an invalid instruction.

Parameters:
WIDTH, 64, datapath width of registers, valC, valP, valA, valB
RSP_ID, 4, register index used as the stack pointer
NONE_ID, 15, register index meaning "no register"

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch packet valid
stall  input  1  hold output register and ignore input
bubble  input  1  load a NOP into the output register
icode  input  4  fetched instruction code
ifun  input  4  fetched function code
rA  input  4  fetched register A
rB  input  4  fetched register B
valC  input  WIDTH  fetched constant
valP  input  WIDTH  fetched next PC
wb_dstE  input  4  writeback E destination, already cnd-resolved; 15 = none
wb_valE  input  WIDTH  writeback E data
wb_dstM  input  4  writeback M destination; 15 = none
wb_valM  input  WIDTH  writeback M data
out_valid  output  1  execute packet valid (execute's enable flag)
e_icode  output  4  to execute
e_ifun  output  4  to execute
e_valC  output  WIDTH  to execute
e_valA  output  WIDTH  to execute
e_valB  output  WIDTH  to execute
e_dstE  output  4  decoded E destination
e_dstM  output  4  decoded M destination
stat  output  2  0=RUN, 1=HALT, 2=ERR

Behaviour:
- Reset (rst_n low, async): all 15 registers = 0; out_valid=0; e_icode=1 (NOP); e_ifun, e_valC, e_valA, e_valB = 0; e_dstE = e_dstM = 15; stat=RUN.
- Writes happen on the rising edge. Index 15 is never written. If wb_dstE == wb_dstM != 15, valM wins.
- Reads: index 15 returns 0.
- srcA = rA for icode 2, 4, 6, A; RSP_ID for 9, B; else 15.
- srcB = rB for icode 4, 5, 6; RSP_ID for 8, 9, A, B; else 15.
- dstE = rB for icode 2, 3, 6; RSP_ID for 8, 9, A, B; else 15.
- dstM = rA for icode 5, B; else 15.
- e_valA = valP for icode 7 and 8; otherwise reg[srcA].
- Latency: one cycle. A packet presented with in_valid=1 at edge N appears on e_* with out_valid=1 after edge N.
- Priority at each edge: stall > bubble > capture.
  - stall=1: all outputs hold.
  - bubble=1: load NOP and out_valid=0.
  - Otherwise in_valid=1 in RUN: capture the packet.
  - Otherwise: out_valid=0, other outputs hold.
- State machine:
  - RUN -> HALT when icode 0 is captured (the halt packet itself is emitted with out_valid=1).
  - RUN -> ERR when icode > 0xB is captured (emitted with out_valid=0).
  - HALT and ERR are terminal until reset: in_valid is ignored, out_valid=0, writeback ports keep writing.
- Reset asserted mid-operation clears registers, state and outputs immediately.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: a read whose source equals a same-cycle writeback destination returns the incoming data (valM takes precedence over valE).
- Not defined: such a read returns the pre-write register value; hazards are left to external stall logic.

Test Plan:
- Reset, then present rrmovq (icode=2, rA=4, rB=2) with reg4=4 -> next cycle out_valid=1, e_valA=4, e_valB=0, e_dstE=2, e_dstM=15.
- Write reg3=7 via wb_dstE=3, then present OPq (icode=6, ifun=0, rA=3, rB=3) -> e_valA=7, e_valB=7.
- Same edge: wb_dstE=4 with valE=0x10 and wb_dstM=4 with valM=0x20 -> reg4=0x20.
- Present call (icode=8, valP=0x40) with rsp=0x100 -> e_valA=0x40, e_valB=0x100, e_dstE=4.
- Present halt then OPq -> stat=HALT; halt packet emitted; the following out_valid stays 0.
- Present icode=0xD -> stat=ERR, out_valid=0.
- With WB_BYPASS_EN: wb_dstE=2 with valE=9 in the same cycle OPq reads rB=2 -> e_valB=9.
- Without WB_BYPASS_EN, same stimulus -> e_valB equals the old reg2 value.
- stall=1 for 3 cycles -> outputs unchanged; bubble=1 -> e_icode=1, out_valid=0.
